// File: rtl/spi_device_pkg.sv
// spi_device_pkg: shared SPI frame constants and byte type for the spi_device slice
package spi_device_pkg;
  localparam int SPI_FRAME_BITS = 8;
  localparam logic [1:0] SPI_MODE = 2'b00;
  localparam int SPI_CNT_W = $clog2(SPI_FRAME_BITS);
  typedef logic [SPI_FRAME_BITS-1:0] spi_byte_t;
endpackage

// File: rtl/spi_device_synchronizer.sv
// spi_device_synchronizer: STAGES-deep flop synchronizer (clk, reset, i_d async in, o_q synced out, RST_VAL on reset)
module spi_device_synchronizer #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  always_ff @(posedge clk)
    if (reset) r_sync <= {STAGES{RST_VAL}};
    else r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/spi_device.sv
// spi_device: SPI mode-0 byte device (raw sck/cs_n/copi pins in, cipo/oe/cs out, rx byte+strobe out, tx byte+strobe in)
module spi_device
  import spi_device_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spi_sck_pin,
  input  logic                      spi_cs_n_pin,
  input  logic                      spi_copi_pin,
  output logic                      spi_cipo,
  output logic                      spi_cipo_oe,
  output logic                      spi_cs,
  output logic [SPI_FRAME_BITS-1:0] spi_rx_data,
  output logic                      spi_rx_strobe,
  input  logic [SPI_FRAME_BITS-1:0] spi_tx_data,
  input  logic                      spi_tx_strobe
);
  logic w_sck, w_cs_n, w_copi, w_active, w_wrap, w_load_now;
  logic r_sck_d, r_rise, r_fall, r_copi, r_armed, r_pending;
  logic [SYNC_STAGES-1:0] r_settle;
  logic [SPI_CNT_W-1:0] r_bit_count;
  logic [SPI_FRAME_BITS-2:0] r_rx_shift;
  spi_byte_t r_tx_shift, r_pend_data;
  spi_device_synchronizer #(
    .WIDTH(3),
    .STAGES(SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk(clk),
    .reset(reset),
    .i_d({spi_sck_pin, spi_cs_n_pin, spi_copi_pin}),
    .o_q({w_sck, w_cs_n, w_copi})
  );
  assign w_active = r_armed & ~w_cs_n;
  assign w_wrap = r_rise & (r_bit_count == '1);
  assign w_load_now = spi_tx_strobe & ((r_bit_count == '0) | w_wrap);
  assign spi_cs = w_cs_n;
  assign spi_cipo_oe = ~w_cs_n;
  assign spi_cipo = ~w_cs_n & r_tx_shift[SPI_FRAME_BITS-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_d <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_copi <= 1'b0;
      r_settle <= '0;
      r_armed <= 1'b0;
      r_bit_count <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_pend_data <= '0;
      r_pending <= 1'b0;
      spi_rx_data <= '0;
      spi_rx_strobe <= 1'b0;
    end else begin
      r_sck_d <= w_sck;
      r_rise <= w_sck & ~r_sck_d;
      r_fall <= ~w_sck & r_sck_d;
      r_copi <= w_copi;
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_armed <= r_armed | (r_settle[SYNC_STAGES-1] & w_cs_n);
      spi_rx_strobe <= w_active & w_wrap;
      if (w_active & w_wrap) spi_rx_data <= {r_rx_shift, r_copi};
      if (!w_active) begin
        r_bit_count <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= '0;
        r_pending <= 1'b0;
      end else begin
        if (r_rise) begin
          r_rx_shift <= {r_rx_shift[SPI_FRAME_BITS-3:0], r_copi};
          r_bit_count <= r_bit_count + 1'b1;
        end
        if (w_load_now) begin
          r_tx_shift <= spi_tx_data;
          r_pending <= 1'b0;
        end else if (w_wrap) begin
          r_tx_shift <= r_pending ? r_pend_data : '0;
          r_pending <= 1'b0;
        end else begin
          if (r_fall && r_bit_count != '0) r_tx_shift <= {r_tx_shift[SPI_FRAME_BITS-2:0], 1'b0};
          if (spi_tx_strobe) begin
            r_pend_data <= spi_tx_data;
            r_pending <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_device.sv
// tb_spi_device: directed scoreboard bench for spi_device driving a mode-0 host model
module tb_spi_device;
  localparam int S = 2;
  localparam int PH = 10;
  logic clk, reset, spi_sck_pin, spi_cs_n_pin, spi_copi_pin;
  logic spi_cipo, spi_cipo_oe, spi_cs, spi_rx_strobe, spi_tx_strobe;
  logic [7:0] spi_rx_data, spi_tx_data;
  logic [7:0] exp_q[$];
  logic [7:0] m;
  logic reply_armed, reply_now;
  logic [7:0] reply_byte;
  int n_asserts, n_fail, cyc, rise_cyc;
  spi_device #(.SYNC_STAGES(S)) dut (
    .clk(clk),
    .reset(reset),
    .spi_sck_pin(spi_sck_pin),
    .spi_cs_n_pin(spi_cs_n_pin),
    .spi_copi_pin(spi_copi_pin),
    .spi_cipo(spi_cipo),
    .spi_cipo_oe(spi_cipo_oe),
    .spi_cs(spi_cs),
    .spi_rx_data(spi_rx_data),
    .spi_rx_strobe(spi_rx_strobe),
    .spi_tx_data(spi_tx_data),
    .spi_tx_strobe(spi_tx_strobe)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    spi_tx_strobe = 1'b0;
    if (reply_now) begin
      spi_tx_data = reply_byte;
      spi_tx_strobe = 1'b1;
      reply_now = 1'b0;
    end
    if (spi_rx_strobe) begin
      if (exp_q.size() == 0) chk("rx_strobe_unexpected", 32'(spi_rx_strobe), 32'd0);
      else begin
        chk("rx_data", 32'(spi_rx_data), 32'(exp_q.pop_front()));
        chk("rx_latency", cyc - rise_cyc, S + 2);
      end
      if (reply_armed) begin
        reply_now = 1'b1;
        reply_armed = 1'b0;
      end
    end
  endtask
  task automatic host_byte(input logic [7:0] mosi, input int nbits, input int mid_bit,
                           input logic [7:0] mid_data, output logic [7:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == mid_bit) begin
        spi_tx_data = mid_data;
        spi_tx_strobe = 1'b1;
      end
      spi_copi_pin = mosi[7-i];
      repeat (PH) tick();
      miso[7-i] = spi_cipo;
      spi_sck_pin = 1'b1;
      rise_cyc = cyc;
      repeat (PH) tick();
      spi_sck_pin = 1'b0;
    end
  endtask
  task automatic chk_reset(input string pfx);
    chk({pfx, "_cs"}, 32'(spi_cs), 32'd1);
    chk({pfx, "_rx_data"}, 32'(spi_rx_data), 32'd0);
    chk({pfx, "_rx_strobe"}, 32'(spi_rx_strobe), 32'd0);
    chk({pfx, "_cipo"}, 32'(spi_cipo), 32'd0);
    chk({pfx, "_cipo_oe"}, 32'(spi_cipo_oe), 32'd0);
  endtask
  initial begin
    n_asserts = 0;
    n_fail = 0;
    cyc = 0;
    rise_cyc = 0;
    reply_armed = 1'b0;
    reply_now = 1'b0;
    reply_byte = '0;
    reset = 1'b1;
    spi_sck_pin = 1'b0;
    spi_cs_n_pin = 1'b1;
    spi_copi_pin = 1'b0;
    spi_tx_data = '0;
    spi_tx_strobe = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    reset = 1'b0;
    repeat (6) tick();
    spi_cs_n_pin = 1'b0;
    repeat (6) tick();
    chk("cs_selected", 32'(spi_cs), 32'd0);
    chk("oe_selected", 32'(spi_cipo_oe), 32'd1);
    chk("cipo_idle", 32'(spi_cipo), 32'd0);
    exp_q.push_back(8'h5A);
    host_byte(8'h5A, 8, -1, 8'h00, m);
    chk("miso_unloaded", 32'(m), 32'h00);
    exp_q.push_back(8'hF2);
    reply_byte = 8'hA5;
    reply_armed = 1'b1;
    host_byte(8'hF2, 8, -1, 8'h00, m);
    chk("miso_cmd", 32'(m), 32'h00);
    exp_q.push_back(8'h33);
    host_byte(8'h33, 8, -1, 8'h00, m);
    chk("miso_reply", 32'(m), 32'hA5);
    exp_q.push_back(8'h11);
    host_byte(8'h11, 8, 4, 8'h3C, m);
    chk("miso_mid_unchanged", 32'(m), 32'h00);
    exp_q.push_back(8'h22);
    host_byte(8'h22, 8, -1, 8'h00, m);
    chk("miso_pending", 32'(m), 32'h3C);
    exp_q.push_back(8'h44);
    host_byte(8'h44, 8, -1, 8'h00, m);
    chk("miso_no_load", 32'(m), 32'h00);
    host_byte(8'hE7, 5, -1, 8'h00, m);
    repeat (PH) tick();
    spi_cs_n_pin = 1'b1;
    repeat (PH) tick();
    chk("cs_deselected", 32'(spi_cs), 32'd1);
    chk("oe_deselected", 32'(spi_cipo_oe), 32'd0);
    spi_cs_n_pin = 1'b0;
    repeat (PH) tick();
    exp_q.push_back(8'h81);
    host_byte(8'h81, 8, -1, 8'h00, m);
    chk("miso_after_abort", 32'(m), 32'h00);
    host_byte(8'hAA, 3, -1, 8'h00, m);
    reset = 1'b1;
    repeat (2) tick();
    chk_reset("midreset");
    reset = 1'b0;
    repeat (6) tick();
    host_byte(8'hFF, 8, -1, 8'h00, m);
    chk("miso_unarmed", 32'(m), 32'h00);
    spi_cs_n_pin = 1'b1;
    repeat (PH) tick();
    spi_cs_n_pin = 1'b0;
    repeat (PH) tick();
    exp_q.push_back(8'hC3);
    host_byte(8'hC3, 8, -1, 8'h00, m);
    repeat (PH) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
